// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode width and the opcode map.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int OPCODE_W  = 5;

    localparam logic [OPCODE_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [OPCODE_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [OPCODE_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [OPCODE_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [OPCODE_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [OPCODE_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [OPCODE_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [OPCODE_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [OPCODE_W-1:0] ALU_OR     = 5'd8;
    localparam logic [OPCODE_W-1:0] ALU_AND    = 5'd9;
    localparam logic [OPCODE_W-1:0] ALU_MUL    = 5'd10;
    localparam logic [OPCODE_W-1:0] ALU_MULH   = 5'd11;
    localparam logic [OPCODE_W-1:0] ALU_MULHSU = 5'd12;
    localparam logic [OPCODE_W-1:0] ALU_MULHU  = 5'd13;
    localparam logic [OPCODE_W-1:0] ALU_DIV    = 5'd14;
    localparam logic [OPCODE_W-1:0] ALU_DIVU   = 5'd15;
    localparam logic [OPCODE_W-1:0] ALU_REM    = 5'd16;
    localparam logic [OPCODE_W-1:0] ALU_REMU   = 5'd17;

endpackage

// File: rtl/alu_divider.sv
// Combinational signed/unsigned divider: truncating quotient, remainder follows
// the dividend's sign, with RISC-V divide-by-zero and overflow results.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic             div_zero;
    logic             overflow;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    always_comb begin
        div_zero  = (divisor == '0);
        overflow  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
        a_neg     = is_signed & dividend[WIDTH-1];
        b_neg     = is_signed & divisor[WIDTH-1];
        a_mag     = a_neg ? ('0 - dividend) : dividend;
        b_mag     = b_neg ? ('0 - divisor) : divisor;
        // Substitute 1 for a zero divisor so the core never divides by zero.
        if (div_zero) begin
            b_mag = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        q_mag     = a_mag / b_mag;
        r_mag     = a_mag % b_mag;
        quotient  = (a_neg ^ b_neg) ? ('0 - q_mag) : q_mag;
        remainder = a_neg ? ('0 - r_mag) : r_mag;

        if (div_zero) begin
            quotient  = '1;
            remainder = dividend;
        end else if (overflow) begin
            quotient  = dividend;
            remainder = '0;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// RV32IM execute-stage ALU: combinational integer/multiply/divide datapath
// captured in a single output register (one-cycle latency).
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [WIDTH-1:0]    DATA1,
    input  logic [WIDTH-1:0]    DATA2,
    input  logic [OPCODE_W-1:0] OPCODE,
    output logic [WIDTH-1:0]    ALU_OUTPUT
);

    logic [4:0]         shamt;
    logic               a_sign;
    logic               b_sign;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic               div_signed;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   result_d;

    assign div_signed = (OPCODE == ALU_DIV) || (OPCODE == ALU_REM);

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .dividend  (DATA1),
        .divisor   (DATA2),
        .is_signed (div_signed),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // One shared multiplier: operand extension picks the signedness per opcode;
    // the low half is identical for every mix, so MUL uses it unconditionally.
    always_comb begin
        shamt   = DATA2[4:0];
        a_sign  = DATA1[WIDTH-1] && ((OPCODE == ALU_MULH) || (OPCODE == ALU_MULHSU));
        b_sign  = DATA2[WIDTH-1] && (OPCODE == ALU_MULH);
        a_ext   = {{WIDTH{a_sign}}, DATA1};
        b_ext   = {{WIDTH{b_sign}}, DATA2};
        product = a_ext * b_ext;

        result_d = '0;
        case (OPCODE)
            ALU_ADD:    result_d = DATA1 + DATA2;
            ALU_SUB:    result_d = DATA1 - DATA2;
            ALU_SLL:    result_d = DATA1 << shamt;
            ALU_SLT:    result_d = {{(WIDTH-1){1'b0}}, ($signed(DATA1) < $signed(DATA2))};
            ALU_SLTU:   result_d = {{(WIDTH-1){1'b0}}, (DATA1 < DATA2)};
            ALU_XOR:    result_d = DATA1 ^ DATA2;
            ALU_SRL:    result_d = DATA1 >> shamt;
            ALU_SRA:    result_d = $unsigned($signed(DATA1) >>> shamt);
            ALU_OR:     result_d = DATA1 | DATA2;
            ALU_AND:    result_d = DATA1 & DATA2;
            ALU_MUL:    result_d = product[WIDTH-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  result_d = product[2*WIDTH-1:WIDTH];
            ALU_DIV,
            ALU_DIVU:   result_d = quotient;
            ALU_REM,
            ALU_REMU:   result_d = remainder;
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ALU_OUTPUT <= '0;
        end else begin
            ALU_OUTPUT <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed literal cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_alu_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [4:0]  OPCODE;
    logic [31:0] ALU_OUTPUT;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q;
    logic        exp_valid = 1'b0;

    alu_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DATA1      (DATA1),
        .DATA2      (DATA2),
        .OPCODE     (OPCODE),
        .ALU_OUTPUT (ALU_OUTPUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
        longint          sa;
        longint          sb;
        longint          ub;
        longint unsigned pu;
        logic [63:0]     p;
        int              ia;
        int              ib;
        int              iq;
        logic [31:0]     r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        r  = 32'h0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << b[4:0];
            5'd3:  r = (ia < ib) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> b[4:0];
            5'd7:  begin
                       // arithmetic shift as floor division by a power of two
                       p = 64'(sa) >> b[4:0];
                       r = a[31] ? (p[31:0] | ~(32'hFFFFFFFF >> b[4:0])) : p[31:0];
                   end
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: begin p = sa * sb; r = p[31:0];  end
            5'd11: begin p = sa * sb; r = p[63:32]; end
            5'd12: begin p = sa * ub; r = p[63:32]; end
            5'd13: begin pu = {32'h0, a} * {32'h0, b}; p = pu; r = p[63:32]; end
            5'd14: begin
                       if (b == 0) r = 32'hFFFFFFFF;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                       else begin iq = ia / ib; r = iq; end
                   end
            5'd15: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            5'd16: begin
                       if (b == 0) r = a;
                       else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                       else begin iq = ia % ib; r = iq; end
                   end
            5'd17: r = (b == 0) ? a : a % b;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always @(posedge CLK) begin
        exp_q     <= RESET ? 32'h0 : model(DATA1, DATA2, OPCODE);
        exp_valid <= 1'b1;
    end

    always @(negedge CLK) begin
        if (exp_valid) begin
            checks++;
            if (ALU_OUTPUT !== exp_q) begin
                errors++;
                $display("FAIL model op=%0d a=%h b=%h: got %h expected %h",
                         OPCODE, DATA1, DATA2, ALU_OUTPUT, exp_q);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] op, input logic rst, input logic [31:0] expv);
        @(negedge CLK);
        DATA1  = a;
        DATA2  = b;
        OPCODE = op;
        RESET  = rst;
        @(negedge CLK);
        checks++;
        if (ALU_OUTPUT !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, ALU_OUTPUT, expv);
        end
    endtask

    logic [31:0] step_exp [18] = '{32'd9, 32'd3, 32'd48, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0,
                                   32'd7, 32'd2, 32'd18, 32'd0, 32'd0, 32'd0,
                                   32'd2, 32'd2, 32'd0, 32'd0};
    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                  32'h7FFFFFFF, 32'hFFFFFFF0};

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        if ($urandom_range(0, 3) == 0) v = specials[$urandom_range(0, 5)];
        else if ($urandom_range(0, 2) == 0) v = $urandom_range(0, 40);
        else v = $urandom;
        return v;
    endfunction

    initial begin
        RESET  = 1'b1;
        DATA1  = 32'd0;
        DATA2  = 32'd0;
        OPCODE = 5'd0;
        repeat (2) @(negedge CLK);
        lit("reset_state", 32'd6, 32'd3, 5'd0, 1'b1, 32'd0);

        for (int i = 0; i < 18; i++) begin
            lit($sformatf("step_op%0d", i), 32'd6, 32'd3, 5'(i), 1'b0, step_exp[i]);
        end

        lit("reset_priority", 32'd6, 32'd3, 5'd0, 1'b1, 32'd0);
        lit("reset_release",  32'd6, 32'd3, 5'd0, 1'b0, 32'd9);

        lit("neg_sra",  32'hFFFFFFF0, 32'd3, 5'd7,  1'b0, 32'hFFFFFFFE);
        lit("neg_srl",  32'hFFFFFFF0, 32'd3, 5'd6,  1'b0, 32'h1FFFFFFE);
        lit("neg_slt",  32'hFFFFFFF0, 32'd3, 5'd3,  1'b0, 32'd1);
        lit("neg_sltu", 32'hFFFFFFF0, 32'd3, 5'd4,  1'b0, 32'd0);
        lit("neg_div",  32'hFFFFFFF0, 32'd3, 5'd14, 1'b0, 32'hFFFFFFFB);
        lit("neg_rem",  32'hFFFFFFF0, 32'd3, 5'd16, 1'b0, 32'hFFFFFFFF);

        lit("dz_div",  32'd7, 32'd0, 5'd14, 1'b0, 32'hFFFFFFFF);
        lit("dz_divu", 32'd7, 32'd0, 5'd15, 1'b0, 32'hFFFFFFFF);
        lit("dz_rem",  32'd7, 32'd0, 5'd16, 1'b0, 32'd7);
        lit("dz_remu", 32'd7, 32'd0, 5'd17, 1'b0, 32'd7);

        lit("ovf_div",   32'h80000000, 32'hFFFFFFFF, 5'd14, 1'b0, 32'h80000000);
        lit("ovf_rem",   32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b0, 32'h0);
        lit("ovf_mulh",  32'h80000000, 32'hFFFFFFFF, 5'd11, 1'b0, 32'h0);
        lit("ovf_mulhu", 32'h80000000, 32'hFFFFFFFF, 5'd13, 1'b0, 32'h7FFFFFFF);
        lit("ovf_mul",   32'h80000000, 32'hFFFFFFFF, 5'd10, 1'b0, 32'h80000000);
        lit("mulhsu_neg", 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 1'b0, 32'hFFFFFFFF);

        lit("sll_shamt", 32'd1, 32'h25, 5'd2,  1'b0, 32'd32);
        lit("reserved",  32'd1, 32'h25, 5'd20, 1'b0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            DATA1  = rand_operand();
            DATA2  = rand_operand();
            OPCODE = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31))
                                                 : 5'($urandom_range(0, 17));
            RESET  = ($urandom_range(0, 49) == 0);
        end
        @(negedge CLK);
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
